// File: rtl/pattern_serializer.sv
// Parallel-to-serial bit source with a one-word holding buffer, feeding a serial pattern detector.
// Latency: a word accepted at edge E is loaded at E+1; its first bit is on sig after E+1.
// Backpressure: in_ready is low while the holding register is full; bits advance only on bit_en.
// Build option SERIALIZER_LSB_FIRST_EN: bits leave LSB first (default MSB first).
module pattern_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bit_en,
  output logic             sig,
  output logic             sig_valid,
  output logic             word_done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh, sh_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] hold_data, hold_data_nxt;
  logic             hold_valid, hold_valid_nxt;

  logic [WIDTH-1:0] sh_shifted;
  logic             cur_bit;
  logic             last_bit;
  logic             accept;

`ifdef SERIALIZER_LSB_FIRST_EN
  assign cur_bit    = sh[0];
  assign sh_shifted = {1'b0, sh[WIDTH-1:1]};
`else
  assign cur_bit    = sh[WIDTH-1];
  assign sh_shifted = {sh[WIDTH-2:0], 1'b0};
`endif

  // Holding register is the only buffer, so readiness is simply "hold empty".
  assign in_ready  = !rst && !hold_valid;
  assign accept    = in_valid && in_ready;
  assign last_bit  = (cnt == CNT_ONE);
  assign sig_valid = (state == SHIFT);
  assign sig       = sig_valid & cur_bit;
  assign word_done = sig_valid && bit_en && last_bit;

  // Next-state: accept into hold, load hold into the shifter when idle or at a word boundary.
  always_comb begin
    state_nxt      = state;
    sh_nxt         = sh;
    cnt_nxt        = cnt;
    hold_data_nxt  = hold_data;
    hold_valid_nxt = hold_valid;

    // Accept and load never coincide: accept needs hold empty, load needs hold full.
    if (accept) begin
      hold_data_nxt  = in_data;
      hold_valid_nxt = 1'b1;
    end

    case (state)
      IDLE: begin
        if (hold_valid) begin
          sh_nxt         = hold_data;
          cnt_nxt        = CNT_FULL;
          hold_valid_nxt = 1'b0;
          state_nxt      = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_en) begin
          if (!last_bit) begin
            sh_nxt  = sh_shifted;
            cnt_nxt = cnt - CNT_ONE;
          end else if (hold_valid) begin
            // Reload straight from hold so the next word follows with no idle bit.
            sh_nxt         = hold_data;
            cnt_nxt        = CNT_FULL;
            hold_valid_nxt = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
    endcase
  end

  // State registers; reset discards both the in-flight and the held word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sh         <= '0;
      cnt        <= '0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      sh         <= sh_nxt;
      cnt        <= cnt_nxt;
      hold_data  <= hold_data_nxt;
      hold_valid <= hold_valid_nxt;
    end
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// Randomized and directed bench for pattern_serializer against a word/bit-level reference model.
// Latency: checks every cycle on the falling edge; the model advances on each rising edge.
// Backpressure: stimulus holds in_valid across full-hold cycles; the model decides acceptance.
module tb_pattern_serializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         bit_en;
  logic         sig;
  logic         sig_valid;
  logic         word_done;

  pattern_serializer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .bit_en(bit_en), .sig(sig), .sig_valid(sig_valid), .word_done(word_done)
  );

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a word being sent with a count of bits still to send, plus one held word.
  int           m_rem = 0;
  logic [W-1:0] m_cur = '0;
  logic [W-1:0] m_hold = '0;
  bit           m_hold_vld = 1'b0;
  int           m_acc = 0;

  // Observed traffic
  logic [63:0]  stream = '0;
  int           nbits = 0;
  int           done_cnt = 0;
  int           valid_cycles = 0;

  // Bit currently on the line: position (W - m_rem) in transmission order.
  function automatic logic m_bit();
`ifdef SERIALIZER_LSB_FIRST_EN
    return m_cur[W - m_rem];
`else
    return m_cur[m_rem - 1];
`endif
  endfunction

  function automatic logic [W-1:0] order(input logic [W-1:0] w);
    logic [W-1:0] r;
`ifdef SERIALIZER_LSB_FIRST_EN
    for (int i = 0; i < W; i++) r[i] = w[W-1-i];
`else
    r = w;
`endif
    return r;
  endfunction

  task automatic model_reset();
    m_rem = 0;
    m_hold_vld = 1'b0;
  endtask

  // One clock: drive inputs, check outputs at negedge, advance model at posedge.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic be);
    bit acc;
    in_valid = v;
    in_data  = d;
    bit_en   = be;
    @(negedge clk);
    chk("sig_valid", 32'(sig_valid), 32'(m_rem > 0));
    chk("sig", 32'(sig), 32'((m_rem > 0) ? m_bit() : 1'b0));
    chk("in_ready", 32'(in_ready), 32'(!m_hold_vld));
    chk("word_done", 32'(word_done), 32'((m_rem == 1) && be));
    if (sig_valid) valid_cycles++;
    if (sig_valid && be) begin
      stream = {stream[62:0], sig};
      nbits++;
    end
    if (word_done) done_cnt++;
    @(posedge clk);
    acc = v && !m_hold_vld;
    if (m_rem == 0) begin
      if (m_hold_vld) begin
        m_cur = m_hold; m_rem = W; m_hold_vld = 1'b0;
      end
    end else if (be) begin
      m_rem--;
      if (m_rem == 0 && m_hold_vld) begin
        m_cur = m_hold; m_rem = W; m_hold_vld = 1'b0;
      end
    end
    if (acc) begin
      m_hold = d; m_hold_vld = 1'b1; m_acc++;
    end
    #1;
  endtask

  task automatic clear_obs();
    stream = '0; nbits = 0; done_cnt = 0; valid_cycles = 0; m_acc = 0;
  endtask

  initial begin
    int d0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; bit_en = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_sig_valid", 32'(sig_valid), 32'd0);
    chk("rst_sig", 32'(sig), 32'd0);
    chk("rst_word_done", 32'(word_done), 32'd0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Single word, bit_en high
    clear_obs();
    cycle(1'b1, 8'b0001_0010, 1'b1);
    for (int k = 0; k < 12; k++) cycle(1'b0, 8'h00, 1'b1);
    chk("single_bits", stream[31:0], 32'(order(8'h12)));
    chk("single_nbits", 32'(nbits), 32'd8);
    chk("single_done", 32'(done_cnt), 32'd1);

    // Back-to-back: A5 then 3C with in_valid held
    clear_obs();
    cycle(1'b1, 8'hA5, 1'b1);
    cycle(1'b1, 8'h3C, 1'b1);
    cycle(1'b1, 8'h3C, 1'b1);
    for (int k = 0; k < 20; k++) cycle(1'b0, 8'h00, 1'b1);
    chk("b2b_bits", stream[31:0], 32'({order(8'hA5), order(8'h3C)}));
    chk("b2b_contig", 32'(valid_cycles), 32'd16);
    chk("b2b_done", 32'(done_cnt), 32'd2);

    // Paced: one strobe in three; 24 cycles from load to completion
    clear_obs();
    cycle(1'b1, 8'hF0, 1'b0);
    for (int k = 0; k < 30; k++) begin
      d0 = done_cnt;
      cycle(1'b0, 8'h00, (k % 3) == 0);
      if (done_cnt != d0) chk("paced_done_cycle", 32'(k), 32'd24);
    end
    chk("paced_bits", stream[31:0], 32'(order(8'hF0)));
    chk("paced_valid_cycles", 32'(valid_cycles), 32'd24);

    // Reset after 3 bits of FF with a second word held
    clear_obs();
    cycle(1'b1, 8'hFF, 1'b1);
    cycle(1'b1, 8'hAA, 1'b1);
    cycle(1'b1, 8'hAA, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    chk("pre_rst_bits", 32'(nbits), 32'd3);
    rst = 1'b1;
    #1;
    chk("mid_rst_sig_valid", 32'(sig_valid), 32'd0);
    chk("mid_rst_sig", 32'(sig), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 12; k++) cycle(1'b0, 8'h00, 1'b1);
    chk("post_rst_no_bits", 32'(nbits), 32'd3);

    // Starved producer: gap between words, then 2-edge latency to the first bit
    clear_obs();
    cycle(1'b1, 8'h5A, 1'b1);
    for (int k = 0; k < 14; k++) cycle(1'b0, 8'h00, 1'b1);
    chk("starve_idle", 32'(sig_valid), 32'd0);
    cycle(1'b1, 8'hC3, 1'b1);
    chk("starve_lat_e", 32'(sig_valid), 32'd0);
    cycle(1'b0, 8'h00, 1'b1);
    chk("starve_lat_e1", 32'(sig_valid), 32'd1);
    for (int k = 0; k < 12; k++) cycle(1'b0, 8'h00, 1'b1);
    chk("starve_bits", stream[31:0], 32'({order(8'h5A), order(8'hC3)}));

    // Randomized traffic against the model
    clear_obs();
    for (int k = 0; k < 600; k++)
      cycle($urandom_range(0, 2) != 0, W'($urandom), $urandom_range(0, 3) != 0);
    for (int k = 0; k < 4 * W; k++) cycle(1'b0, 8'h00, 1'b1);
    chk("rand_words", 32'(done_cnt), 32'(m_acc));
    chk("rand_bits", 32'(nbits), 32'(m_acc * W));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
